// File: rtl/gcd_axi_pkg.sv
// Shared constants, FSM encoding and burst legality check for the GCD AXI4 burst master.
package gcd_axi_pkg;

   localparam int unsigned DATA_W      = 64;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned LEN_W       = 8;
   localparam int unsigned STRB_W      = DATA_W / 8;
   localparam int unsigned ID_W        = 4;
   localparam int unsigned PAGE_OFF_W  = 12;
   localparam int unsigned PAGE_SUM_W  = 13;
   localparam int unsigned PAGE_BYTES  = 4096;

   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [2:0] SIZE_8B       = 3'b011;
   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CHECK, ST_AR, ST_R, ST_AW, ST_W, ST_B, ST_FIN
   } state_t;

   // Misaligned start, or the burst's last byte lands past the 4 KB page.
   function automatic logic burst_illegal(input logic [PAGE_OFF_W-1:0] page_off,
                                          input logic [LEN_W-1:0]      len);
      logic [PAGE_SUM_W-1:0] end_off;
      end_off = PAGE_SUM_W'(page_off) + ((PAGE_SUM_W'(len) + PAGE_SUM_W'(1)) << 3);
      return (page_off[2:0] != 3'b000) || (end_off > PAGE_SUM_W'(PAGE_BYTES));
   endfunction

endpackage

// File: rtl/gcd_axi_master.sv
// AXI4 burst initiator: one INCR read or write burst per command, streams passed through combinationally.
module gcd_axi_master
   import gcd_axi_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'h0
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic        CMD_WRITE,
   input  logic [31:0] CMD_ADDR,
   input  logic [7:0]  CMD_LEN,
   input  logic [63:0] WS_DATA,
   input  logic        WS_VALID,
   output logic        WS_READY,
   output logic [63:0] RS_DATA,
   output logic        RS_LAST,
   output logic        RS_VALID,
   input  logic        RS_READY,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [3:0]  M_AXI_AWID,
   output logic [31:0] M_AXI_AWADDR,
   output logic [7:0]  M_AXI_AWLEN,
   output logic [2:0]  M_AXI_AWSIZE,
   output logic [1:0]  M_AXI_AWBURST,
   output logic        M_AXI_AWLOCK,
   output logic [3:0]  M_AXI_AWCACHE,
   output logic [2:0]  M_AXI_AWPROT,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [63:0] M_AXI_WDATA,
   output logic [7:0]  M_AXI_WSTRB,
   output logic        M_AXI_WLAST,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [3:0]  M_AXI_BID,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [3:0]  M_AXI_ARID,
   output logic [31:0] M_AXI_ARADDR,
   output logic [7:0]  M_AXI_ARLEN,
   output logic [2:0]  M_AXI_ARSIZE,
   output logic [1:0]  M_AXI_ARBURST,
   output logic        M_AXI_ARLOCK,
   output logic [3:0]  M_AXI_ARCACHE,
   output logic [2:0]  M_AXI_ARPROT,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [3:0]  M_AXI_RID,
   input  logic [63:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RLAST,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   state_t             state, state_next;
   logic [LEN_W-1:0]   beat_cnt, cnt_next;
   logic               err_flag, err_next;
   logic               wr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [LEN_W-1:0]   len_q;
   logic               cmd_ready_q, busy_q, done_q, err_q;
   logic               arvalid_q, awvalid_q, bready_q, wlast_q;
   logic               r_hs, w_hs;

   // Response IDs carry no information for a single-outstanding master.
   logic unused_ids;
   assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

   assign r_hs = (state == ST_R) && M_AXI_RVALID && RS_READY;
   assign w_hs = (state == ST_W) && WS_VALID && M_AXI_WREADY;

   // Next-state, beat counter and sticky error flag.
   always_comb begin
      state_next = state;
      cnt_next   = beat_cnt;
      err_next   = err_flag;
      unique case (state)
         ST_IDLE: begin
            cnt_next = '0;
            err_next = 1'b0;
            if (CMD_VALID) state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (burst_illegal(addr_q[PAGE_OFF_W-1:0], len_q)) begin
               err_next   = 1'b1;
               state_next = ST_FIN;
            end else begin
               state_next = wr_q ? ST_AW : ST_AR;
            end
         end
         ST_AR: if (M_AXI_ARREADY) state_next = ST_R;
         ST_R: begin
            if (r_hs) begin
               cnt_next = beat_cnt + LEN_W'(1);
               if (M_AXI_RRESP != RESP_OKAY) err_next = 1'b1;
               if (M_AXI_RLAST) begin
                  if (beat_cnt != len_q) err_next = 1'b1;
                  state_next = ST_FIN;
               end
            end
         end
         ST_AW: if (M_AXI_AWREADY) state_next = ST_W;
         ST_W: begin
            if (w_hs) begin
               cnt_next = beat_cnt + LEN_W'(1);
               if (beat_cnt == len_q) state_next = ST_B;
            end
         end
         ST_B: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != RESP_OKAY) err_next = 1'b1;
               state_next = ST_FIN;
            end
         end
         ST_FIN:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state       <= ST_IDLE;
         beat_cnt    <= '0;
         err_flag    <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         arvalid_q   <= 1'b0;
         awvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         wlast_q     <= 1'b0;
      end else begin
         state    <= state_next;
         beat_cnt <= cnt_next;
         err_flag <= err_next;
         if ((state == ST_IDLE) && CMD_VALID) begin
            wr_q   <= CMD_WRITE;
            addr_q <= CMD_ADDR;
            len_q  <= CMD_LEN;
         end
         cmd_ready_q <= (state_next == ST_IDLE);
         busy_q      <= (state_next != ST_IDLE);
         done_q      <= (state_next == ST_FIN);
         err_q       <= (state_next == ST_FIN) && err_next;
         arvalid_q   <= (state_next == ST_AR);
         awvalid_q   <= (state_next == ST_AW);
         bready_q    <= (state_next == ST_B);
         wlast_q     <= (state_next == ST_W) && (cnt_next == len_q);
      end
   end

   assign CMD_READY = cmd_ready_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ERR       = err_q;

   // Address channels share the latched command; only the VALIDs differ.
   assign M_AXI_AWID    = AXI_ID;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWLEN   = len_q;
   assign M_AXI_AWSIZE  = SIZE_8B;
   assign M_AXI_AWBURST = BURST_INCR;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = CACHE_DEFAULT;
   assign M_AXI_AWPROT  = PROT_DEFAULT;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_ARID    = AXI_ID;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARLEN   = len_q;
   assign M_AXI_ARSIZE  = SIZE_8B;
   assign M_AXI_ARBURST = BURST_INCR;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = CACHE_DEFAULT;
   assign M_AXI_ARPROT  = PROT_DEFAULT;
   assign M_AXI_ARVALID = arvalid_q;

   // Zero-latency stream pass-through, gated by the owning state.
   assign M_AXI_WDATA  = WS_DATA;
   assign M_AXI_WSTRB  = {STRB_W{1'b1}};
   assign M_AXI_WLAST  = wlast_q;
   assign M_AXI_WVALID = (state == ST_W) && WS_VALID;
   assign WS_READY     = (state == ST_W) && M_AXI_WREADY;
   assign M_AXI_BREADY = bready_q;
   assign RS_DATA      = M_AXI_RDATA;
   assign RS_LAST      = M_AXI_RLAST;
   assign RS_VALID     = (state == ST_R) && M_AXI_RVALID;
   assign M_AXI_RREADY = (state == ST_R) && RS_READY;

endmodule

// File: tb/tb_gcd_axi_master.sv
// Directed plus randomized bench for gcd_axi_master with a behavioural AXI slave and reference model.
module tb_gcd_axi_master;

   localparam logic [3:0] TB_ID = 4'h5;

   logic        CLK = 1'b0;
   logic        RESETn;
   logic        CMD_VALID, CMD_READY, CMD_WRITE;
   logic [31:0] CMD_ADDR;
   logic [7:0]  CMD_LEN;
   logic [63:0] WS_DATA;
   logic        WS_VALID, WS_READY;
   logic [63:0] RS_DATA;
   logic        RS_LAST, RS_VALID, RS_READY;
   logic        BUSY, DONE, ERR;
   logic [3:0]  M_AXI_AWID, M_AXI_ARID, M_AXI_BID, M_AXI_RID;
   logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR;
   logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN, M_AXI_WSTRB;
   logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
   logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_AWLOCK, M_AXI_ARLOCK;
   logic [3:0]  M_AXI_AWCACHE, M_AXI_ARCACHE;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic [63:0] M_AXI_WDATA, M_AXI_RDATA;
   logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
   logic        M_AXI_BVALID, M_AXI_BREADY;
   logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

   int vectors = 0;
   int miscompares = 0;

   gcd_axi_master #(.AXI_ID(TB_ID)) dut (
      .CLK(CLK), .RESETn(RESETn),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
      .WS_DATA(WS_DATA), .WS_VALID(WS_VALID), .WS_READY(WS_READY),
      .RS_DATA(RS_DATA), .RS_LAST(RS_LAST), .RS_VALID(RS_VALID), .RS_READY(RS_READY),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
      .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
      .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
      .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
      .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One command end to end. mode: 0 zero-wait, 1 toggling ready, 2 random valid/ready.
   task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                          input int mode, input logic [1:0] bresp, input int bad_beat,
                          input int early_last, input int abort_beat, input logic [63:0] first_data);
      bit illegal, exp_err, addr_done, data_done, fin, hs, rv_hold, wv_hold, rdy_t, pick;
      int nbeats, beat, b_wait;
      logic [63:0] cur;
      illegal = (addr[2:0] != 3'd0) || ((int'(addr[11:0]) + (int'(len) + 1) * 8) > 4096);
      nbeats  = (!wr && early_last >= 0) ? early_last + 1 : int'(len) + 1;
      if (wr) exp_err = illegal || (bresp != 2'b00);
      else    exp_err = illegal || (bad_beat >= 0 && bad_beat < nbeats) || (nbeats != int'(len) + 1);

      @(negedge CLK);
      chk("cmd_ready_idle", 64'(CMD_READY), 64'(1));
      CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_LEN = len;
      @(negedge CLK);
      CMD_VALID = 1'b0; CMD_ADDR = $urandom; CMD_LEN = 8'($urandom);
      chk("check_cycle", 64'({BUSY, DONE, CMD_READY, M_AXI_AWVALID, M_AXI_ARVALID}), 64'(5'b10000));
      @(negedge CLK);
      if (illegal) begin
         chk("illegal_done", 64'({DONE, ERR, M_AXI_AWVALID, M_AXI_ARVALID}), 64'(4'b1100));
         @(negedge CLK);
         chk("illegal_idle", 64'({DONE, BUSY, CMD_READY, M_AXI_AWVALID, M_AXI_ARVALID}), 64'(5'b00100));
         return;
      end

      beat = 0; addr_done = 0; data_done = 0; fin = 0; rv_hold = 0; wv_hold = 0; rdy_t = 1;
      cur = first_data;
      b_wait = (mode == 2) ? $urandom_range(2, 0) : 0;
      for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
         M_AXI_ARREADY = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_BVALID = 1'b0;
         pick = (mode == 0) ? 1'b1 : (mode == 1) ? rdy_t : 1'($urandom_range(1, 0));
         if (!addr_done) begin
            if (wr) begin
               chk("aw_payload", 64'({M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
                                      M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT}),
                   64'({TB_ID, addr, len, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000}));
               chk("aw_valid", 64'({M_AXI_AWVALID, M_AXI_ARVALID}), 64'(2'b10));
               M_AXI_AWREADY = pick;
            end else begin
               chk("ar_payload", 64'({M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
                                      M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT}),
                   64'({TB_ID, addr, len, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000}));
               chk("ar_valid", 64'({M_AXI_ARVALID, M_AXI_AWVALID}), 64'(2'b10));
               M_AXI_ARREADY = pick;
            end
            if (pick) addr_done = 1;
         end else if (!wr) begin
            if (!rv_hold) M_AXI_RVALID = (mode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
            M_AXI_RDATA = cur;
            M_AXI_RLAST = (beat == nbeats - 1);
            M_AXI_RRESP = (beat == bad_beat) ? 2'b11 : 2'b00;
            RS_READY = pick;
            #1;
            chk("rs_data", RS_DATA, cur);
            chk("rs_ctrl", 64'({RS_VALID, RS_LAST, M_AXI_RREADY}),
                64'({M_AXI_RVALID, (beat == nbeats - 1), pick}));
            hs = M_AXI_RVALID && pick;
            rv_hold = M_AXI_RVALID && !hs;
            if (hs) begin
               beat++;
               cur = {$urandom, $urandom};
               if (beat == nbeats) fin = 1;
            end
         end else if (!data_done) begin
            if (!wv_hold) WS_VALID = (mode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
            WS_DATA = cur;
            M_AXI_WREADY = pick;
            if (beat == abort_beat) begin
               RESETn = 1'b0;
               #1;
               chk("rst_ctrl", 64'({CMD_READY, BUSY, DONE, ERR, M_AXI_AWVALID, M_AXI_ARVALID, M_AXI_WVALID,
                                    M_AXI_WLAST, WS_READY, M_AXI_BREADY, RS_VALID, M_AXI_RREADY}),
                   64'(12'b1000_0000_0000));
               chk("rst_addr", 64'({M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_ARLEN}), 64'(0));
               WS_VALID = 1'b0; M_AXI_WREADY = 1'b0;
               @(negedge CLK);
               RESETn = 1'b1;
               @(negedge CLK);
               chk("post_rst", 64'({CMD_READY, BUSY, DONE}), 64'(3'b100));
               return;
            end
            #1;
            chk("w_data", M_AXI_WDATA, cur);
            chk("w_ctrl", 64'({M_AXI_WVALID, M_AXI_WLAST, M_AXI_WSTRB, WS_READY}),
                64'({WS_VALID, (beat == int'(len)), 8'hFF, pick}));
            hs = WS_VALID && pick;
            wv_hold = WS_VALID && !hs;
            if (hs) begin
               beat++;
               cur = {$urandom, $urandom};
               if (beat == int'(len) + 1) data_done = 1;
            end
         end else begin
            WS_VALID = 1'b0; M_AXI_WREADY = 1'b0;
            M_AXI_BVALID = (b_wait == 0);
            M_AXI_BRESP = bresp;
            M_AXI_BID = 4'($urandom);
            #1;
            chk("b_ready", 64'({M_AXI_BREADY, WS_READY, M_AXI_WVALID}), 64'(3'b100));
            if (M_AXI_BVALID) fin = 1;
            else b_wait--;
         end
         rdy_t = !rdy_t;
         @(negedge CLK);
      end
      M_AXI_RVALID = 1'b0; RS_READY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_ARREADY = 1'b0;
      M_AXI_AWREADY = 1'b0; WS_VALID = 1'b0; M_AXI_WREADY = 1'b0;
      chk("finished_in_budget", 64'(fin), 64'(1));
      chk("done_pulse", 64'({DONE, ERR, BUSY}), 64'({1'b1, exp_err, 1'b1}));
      chk("beat_count", 64'(beat), 64'(nbeats));
      @(negedge CLK);
      chk("back_idle", 64'({DONE, ERR, BUSY, CMD_READY}), 64'(4'b0001));
   endtask

   initial begin
      bit          r_wr;
      logic [31:0] r_addr;
      logic [7:0]  r_len;
      logic [1:0]  r_bresp;
      int          r_bad, r_early;

      RESETn = 1'b0;
      CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_LEN = '0;
      WS_DATA = '0; WS_VALID = 1'b0; RS_READY = 1'b0;
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
      M_AXI_BID = '0; M_AXI_BRESP = '0; M_AXI_BVALID = 1'b0;
      M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0;
      #12;
      chk("reset_ctrl", 64'({CMD_READY, BUSY, DONE, ERR, M_AXI_AWVALID, M_AXI_ARVALID, M_AXI_WVALID,
                             M_AXI_WLAST, WS_READY, M_AXI_BREADY, RS_VALID, M_AXI_RREADY}),
          64'(12'b1000_0000_0000));
      chk("reset_addr", 64'({M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_ARLEN}), 64'(0));
      @(negedge CLK);
      RESETn = 1'b1;

      run_cmd(1'b0, 32'h0000_1000, 8'd3,  0, 2'b00, -1, -1, -1, 64'h1111_2222_3333_4444);
      run_cmd(1'b1, 32'h0000_2000, 8'd0,  0, 2'b00, -1, -1, -1, 64'hDEADBEEF_CAFEF00D);
      run_cmd(1'b0, 32'h0000_3040, 8'd7,  1, 2'b00, -1, -1, -1, 64'h0123_4567_89AB_CDEF);
      run_cmd(1'b1, 32'h0000_4080, 8'd7,  1, 2'b00, -1, -1, -1, 64'hFEDC_BA98_7654_3210);
      run_cmd(1'b0, 32'h0000_0FF8, 8'd1,  0, 2'b00, -1, -1, -1, 64'h0);
      run_cmd(1'b1, 32'h0000_1004, 8'd0,  0, 2'b00, -1, -1, -1, 64'h0);
      run_cmd(1'b0, 32'h0000_3F00, 8'd31, 0, 2'b00, -1, -1, -1, 64'hA5A5_A5A5_5A5A_5A5A);
      run_cmd(1'b1, 32'h0000_3F08, 8'd31, 0, 2'b00, -1, -1, -1, 64'h0);
      run_cmd(1'b1, 32'h0000_5000, 8'd2,  0, 2'b10, -1, -1, -1, 64'h5555_0000_5555_0000);
      run_cmd(1'b0, 32'h0000_6000, 8'd3,  0, 2'b00,  2, -1, -1, 64'h6666_0000_6666_0000);
      run_cmd(1'b0, 32'h0000_7000, 8'd3,  0, 2'b00, -1,  1, -1, 64'h7777_0000_7777_0000);
      run_cmd(1'b1, 32'h0000_8000, 8'd15, 0, 2'b00, -1, -1,  5, 64'h8888_0000_8888_0000);
      run_cmd(1'b1, 32'h0000_9000, 8'd3,  0, 2'b00, -1, -1, -1, 64'h9999_0000_9999_0000);
      run_cmd(1'b0, 32'h0000_A000, 8'd2,  0, 2'b00, -1, -1, -1, 64'hAAAA_0000_AAAA_0000);

      for (int i = 0; i < 16; i++) begin
         r_wr   = 1'($urandom_range(1, 0));
         r_len  = 8'($urandom_range(15, 0));
         if ($urandom_range(9, 0) == 0) r_len = 8'($urandom_range(255, 0));
         r_addr = $urandom & 32'hFFFF_FFF8;
         if ($urandom_range(2, 0) == 0) r_addr[11:0] = 12'(4096 - 8 * $urandom_range(20, 1));
         if ($urandom_range(5, 0) == 0) r_addr[2:0] = 3'($urandom_range(7, 1));
         r_bresp = ($urandom_range(3, 0) == 0) ? 2'b10 : 2'b00;
         r_bad   = ($urandom_range(3, 0) == 0) ? $urandom_range(int'(r_len), 0) : -1;
         r_early = (r_len != 8'd0 && $urandom_range(5, 0) == 0) ? $urandom_range(int'(r_len) - 1, 0) : -1;
         run_cmd(r_wr, r_addr, r_len, 2, r_bresp, r_bad, r_early, -1, {$urandom, $urandom});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
